// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types and helpers for the single-port RAM controller.
// Optional feature macro used by this block: RAM_PARITY_EN (adds a stored even-parity bit).
package ram_pkg;

    // Controller states: normal access, or hardware clear sweep in progress
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_t;

    // Widest data word the parity helper handles; narrower words are zero-extended
    localparam int PAR_MAXW = 64;

    // Even-parity bit: makes the total count of ones (data + parity) even
    function automatic logic parity_even(input logic [PAR_MAXW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Bare single-port storage: one synchronous write port and one registered read port.
// Contents are never reset so the array maps onto block RAM.
module ram_sp_array #(
    parameter int W     = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata_ext,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata_ext
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Synchronous write and registered read; the read register updates every cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata_ext;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata_ext = rdata_q;

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: access decode, range/illegal-op checks, clear sweep FSM,
// read-valid and error strobes, optional parity check.
// Optional feature macro: RAM_PARITY_EN (stores one even-parity bit per word, DW <= 64).
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 1024,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          ready,
    input  logic          clr,
    output logic          busy,
    output logic          err,
    output logic          par_err
);

`ifdef RAM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ram_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic          rd_hit_q, rd_hit_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          accept;
    logic          addr_oor;
    logic          op_rd;
    logic          op_wr;
    logic          op_both;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] ram_word;
    logic [DW-1:0] ram_data;

    // A clear request in IDLE takes precedence, so a coincident rd/wr is not accepted
    assign accept   = (state_q == ST_IDLE) && !clr && cs;
    assign addr_oor = ({1'b0, addr} >= DEPTH_EXT);
    assign op_rd    = accept && rd && !wr;
    assign op_wr    = accept && wr && !rd;
    assign op_both  = accept && rd && wr;

    // Out-of-range reads are steered to word 0 to stay inside the array; their data is discarded
    assign mem_raddr = addr_oor ? '0 : addr;

`ifdef RAM_PARITY_EN
    assign wr_word = {parity_even(PAR_MAXW'(wdata)), wdata};
`else
    assign wr_word = wdata;
`endif

    // State and sweep counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: enter CLEAR on clr in IDLE, leave after the last word is written
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs per state: status flags and the array write port (user write or sweep write)
    always_comb begin
        busy      = 1'b0;
        mem_we    = op_wr && !addr_oor;
        mem_waddr = addr;
        mem_wdata = wr_word;
        if (state_q == ST_CLEAR) begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end
        ready = !busy;
    end

    ram_sp_array #(
        .W     (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata_ext (mem_wdata),
        .raddr     (mem_raddr),
        .rdata_ext (ram_word)
    );

    assign ram_data = ram_word[DW-1:0];

    // Next values of the strobes and of the held read data
    always_comb begin
        rd_hit_d = op_rd && !addr_oor;
        rvalid_d = op_rd;
        err_d    = op_both || ((op_rd || op_wr) && addr_oor);
        rdata_d  = rdata_q;
        // Capture the word currently shown from the array so it holds once rvalid drops
        if (rd_hit_q) begin
            rdata_d = ram_data;
        end
        // Out-of-range read returns zero
        if (op_rd && addr_oor) begin
            rdata_d = '0;
        end
    end

    // Output strobe and read-data hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_q <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_hit_q <= rd_hit_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // In-range read data comes straight from the array's read register; otherwise the held value
    assign rdata  = rd_hit_q ? ram_data : rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

`ifdef RAM_PARITY_EN
    assign par_err = rd_hit_q && (parity_even(PAR_MAXW'(ram_data)) != ram_word[DW]);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Self-checking bench for ram_sp_ctrl (DEPTH=1000, DW=8): vector table, clear sweep,
// randomized traffic against a memory model, reset mid-sweep, parity (RAM_PARITY_EN).
module tb_ram_sp_ctrl;

    localparam int DEPTH = 1000;
    localparam int DW    = 8;
    localparam int AW    = 10;

    logic          clk;
    logic          rst_n;
    logic          cs, rd, wr, clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid, ready, busy, err, par_err;

    int n_vec  = 0;
    int n_miss = 0;

    ram_sp_ctrl #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .ready   (ready),
        .clr     (clr),
        .busy    (busy),
        .err     (err),
        .par_err (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          cs;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_rvalid;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    logic [DW-1:0] model [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge
    task automatic step(input logic c, input logic r, input logic w, input logic cl,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cs = c; rd = r; wr = w; clr = cl; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic [DW-1:0] d);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, AW'(a), d);
        end
    endtask

    initial begin
        int            busy_cycles;
        int            bad_strobes;
        bit            done;
        logic          r_cs, r_rd, r_wr;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_d;
        logic          e_rv, e_err;
        logic [DW-1:0] e_rdata;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 10'd5,    8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 10'd5,    8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'd5,    8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 10'd7,    8'h3C, 1'b0, 1'b0, 8'hA5};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 10'd7,    8'h99, 1'b0, 1'b1, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'd7,    8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 10'd7,    8'h00, 1'b1, 1'b0, 8'h3C};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 10'd1000, 8'h11, 1'b0, 1'b1, 8'h3C};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 10'd1000, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 10'd0,    8'h00, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 10'd5,    8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 10'd7,    8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 10'd999,  8'h5A, 1'b0, 1'b0, 8'hA5};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 10'd999,  8'h00, 1'b1, 1'b0, 8'h5A};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 10'd5,    8'h42, 1'b0, 1'b0, 8'h5A};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 10'd5,    8'h00, 1'b1, 1'b0, 8'h42};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 10'd1000, 8'h00, 1'b0, 1'b0, 8'h42};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 1'b1, 8'h00};

        // Reset state
        rst_n = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; clr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata",   32'(rdata),   32'h0);
        chk("reset_rvalid",  32'(rvalid),  32'h0);
        chk("reset_busy",    32'(busy),    32'h0);
        chk("reset_ready",   32'(ready),   32'h1);
        chk("reset_err",     32'(err),     32'h0);
        chk("reset_par_err", 32'(par_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: basic write/read, illegal op, out-of-range, hold, RAW
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].cs, tbl[i].rd, tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].wdata);
            $display("vec %0d: cs=%0b rd=%0b wr=%0b addr=%0d -> rvalid=%0b err=%0b rdata=%02h",
                     i, tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].addr, rvalid, err, rdata);
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid),  32'(tbl[i].exp_rvalid));
            chk($sformatf("vec%0d_err", i),    32'(err),     32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_rdata", i),  32'(rdata),   32'(tbl[i].exp_rdata));
            chk($sformatf("vec%0d_busy", i),   32'(busy),    32'h0);
            chk($sformatf("vec%0d_par", i),    32'(par_err), 32'h0);
        end

        // Clear sweep: fill with FF, clr together with a read (clr wins), count busy cycles
        fill_all(8'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 10'd5, 8'h00);
        $display("clr start: busy=%0b ready=%0b rvalid=%0b err=%0b", busy, ready, rvalid, err);
        chk("clr_busy",   32'(busy),   32'h1);
        chk("clr_ready",  32'(ready),  32'h0);
        chk("clr_rvalid", 32'(rvalid), 32'h0);
        chk("clr_err",    32'(err),    32'h0);
        busy_cycles = 1;
        bad_strobes = 0;
        done        = 1'b0;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            step(1'b1, ~c[0], c[0], (c >= 500 && c < 600), AW'($urandom_range(0, DEPTH - 1)), 8'hFF);
            if (rvalid || err || (ready == busy)) bad_strobes++;
            if (busy) busy_cycles++;
            else begin
                done = 1'b1;
                break;
            end
        end
        $display("clr sweep: busy_cycles=%0d bad_strobes=%0d done=%0b", busy_cycles, bad_strobes, done);
        chk("sweep_ended",  32'(done),      32'h1);
        chk("sweep_cycles", 32'(busy_cycles), 32'(DEPTH));
        chk("sweep_strobes", 32'(bad_strobes), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00);
        chk("clr_not_queued", 32'(busy), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 8'h00);
        $display("post-clr read 0: rvalid=%0b rdata=%02h", rvalid, rdata);
        chk("postclr_rv0", 32'(rvalid), 32'h1);
        chk("postclr_rd0", 32'(rdata),  32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'd500, 8'h00);
        $display("post-clr read 500: rvalid=%0b rdata=%02h", rvalid, rdata);
        chk("postclr_rd500", 32'(rdata), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'(DEPTH - 1), 8'h00);
        $display("post-clr read %0d: rvalid=%0b rdata=%02h", DEPTH - 1, rvalid, rdata);
        chk("postclr_rdlast", 32'(rdata), 32'h0);

        // Randomized traffic against the memory model; everything is zero after the sweep
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        e_rdata = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r_cs   = ($urandom_range(0, 3) != 0);
            r_rd   = 1'($urandom_range(0, 1));
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 1023))
                                                 : AW'($urandom_range(0, DEPTH - 1));
            r_d    = 8'($urandom);
            step(r_cs, r_rd, r_wr, 1'b0, r_addr, r_d);
            e_rv  = 1'b0;
            e_err = 1'b0;
            if (r_cs) begin
                if (r_rd && r_wr) begin
                    e_err = 1'b1;
                end else if (r_wr) begin
                    if (int'(r_addr) < DEPTH) model[r_addr] = r_d;
                    else e_err = 1'b1;
                end else if (r_rd) begin
                    e_rv = 1'b1;
                    if (int'(r_addr) < DEPTH) e_rdata = model[r_addr];
                    else begin
                        e_rdata = 8'h00;
                        e_err   = 1'b1;
                    end
                end
            end
            $display("rnd %0d: cs=%0b rd=%0b wr=%0b addr=%0d wd=%02h -> rvalid=%0b err=%0b rdata=%02h",
                     n, r_cs, r_rd, r_wr, r_addr, r_d, rvalid, err, rdata);
            chk("rnd_rvalid", 32'(rvalid),  32'(e_rv));
            chk("rnd_err",    32'(err),     32'(e_err));
            chk("rnd_rdata",  32'(rdata),   32'(e_rdata));
            chk("rnd_par",    32'(par_err), 32'h0);
        end

        // Reset in the middle of a sweep: words 0..9 cleared, the rest keep FF
        fill_all(8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 8'h00);
        chk("rst_sweep_busy", 32'(busy), 32'h1);
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("mid-sweep reset: busy=%0b ready=%0b rvalid=%0b err=%0b rdata=%02h",
                 busy, ready, rvalid, err, rdata);
        chk("midrst_busy",   32'(busy),   32'h0);
        chk("midrst_ready",  32'(ready),  32'h1);
        chk("midrst_rvalid", 32'(rvalid), 32'h0);
        chk("midrst_rdata",  32'(rdata),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 10; a++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, AW'(a), 8'h00);
            $display("midrst read %0d: rvalid=%0b rdata=%02h", a, rvalid, rdata);
            chk($sformatf("midrst_rd%0d", a), 32'(rdata), 32'h0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'd20, 8'h00);
        $display("midrst read 20: rvalid=%0b rdata=%02h", rvalid, rdata);
        chk("midrst_rd20_rv", 32'(rvalid), 32'h1);
        chk("midrst_rd20",    32'(rdata),  32'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'(DEPTH - 1), 8'h00);
        chk("midrst_rdlast", 32'(rdata), 32'hFF);

        // Parity: corrupt one stored bit and read it back
`ifdef RAM_PARITY_EN
        step(1'b1, 1'b0, 1'b1, 1'b0, 10'd3, 8'h96);
        dut.u_array.mem[3] = dut.u_array.mem[3] ^ 9'h001;
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'd3, 8'h00);
        $display("parity read 3: rvalid=%0b par_err=%0b rdata=%02h", rvalid, par_err, rdata);
        chk("par_rvalid", 32'(rvalid),  32'h1);
        chk("par_err",    32'(par_err), 32'h1);
        chk("par_rdata",  32'(rdata),   32'h97);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00);
        chk("par_err_pulse", 32'(par_err), 32'h0);
`else
        step(1'b1, 1'b1, 1'b0, 1'b0, 10'd3, 8'h00);
        $display("parity read 3: rvalid=%0b par_err=%0b rdata=%02h", rvalid, par_err, rdata);
        chk("par_rvalid", 32'(rvalid),  32'h1);
        chk("par_err",    32'(par_err), 32'h0);
        chk("par_rdata",  32'(rdata),   32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
